// File: rtl/pwm_meter.sv
// Measures period and high time of an asynchronous PWM input and derives duty (%) and frequency (Hz).
// Latency: results and meas_valid appear 65 cycles after the capture (rise) cycle; the timeout report appears 1 cycle after detection.
// Backpressure: none; a rise that arrives while a division is in progress still restarts the counters, but its capture is dropped.
module pwm_meter #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int CNT_W   = 24,
    parameter int TIMEOUT = 10_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period_cyc,
    output logic [CNT_W-1:0] high_cyc,
    output logic [6:0]       duty_pct,
    output logic [15:0]      freq_hz,
    output logic             meas_valid,
    output logic             no_signal,
    output logic             busy
);

    localparam logic [CNT_W-1:0] L_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] L_ONE     = CNT_W'(1);
    localparam logic [31:0]      L_CLK_HZ  = 32'(CLK_HZ);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DIV_DUTY = 2'd1,
        S_DIV_FREQ = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_sync1;
    logic             r_pwm_s;
    logic             r_pwm_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hcnt;
    logic             r_armed;
    logic             r_to_fired;
    logic [CNT_W-1:0] r_p;
    logic [CNT_W-1:0] r_h;
    logic [31:0]      r_num;
    logic [31:0]      r_rem;
    logic [31:0]      r_den;
    logic [4:0]       r_bit;
    logic [6:0]       r_duty;

    logic             w_rise;
    logic [CNT_W-1:0] w_h_cap;
    logic [31:0]      w_duty_num;
    logic             w_timeout;
    logic [32:0]      w_rem_sh;
    logic             w_ge;
    logic [31:0]      w_rem_nx;
    logic [31:0]      w_num_nx;
    logic [6:0]       w_duty_sat;
    logic [15:0]      w_freq_sat;

    assign w_rise     = r_pwm_s & ~r_pwm_d;
    // High count can exceed the period only when both have saturated differently.
    assign w_h_cap    = (r_hcnt < r_cnt) ? r_hcnt : r_cnt;
    assign w_duty_num = 32'(w_h_cap) * 32'd100;
    // Fires once per stuck episode; a rise in the same cycle takes priority.
    assign w_timeout  = (r_cnt == L_TIMEOUT) && !r_to_fired && !w_rise;

    // One restoring-divider step: shift in the next dividend bit, subtract if it fits.
    assign w_rem_sh   = {r_rem, r_num[31]};
    assign w_ge       = (w_rem_sh >= {1'b0, r_den});
    assign w_rem_nx   = w_ge ? 32'(w_rem_sh - {1'b0, r_den}) : w_rem_sh[31:0];
    assign w_num_nx   = {r_num[30:0], w_ge};
    assign w_duty_sat = (w_num_nx > 32'd100)   ? 7'd100    : w_num_nx[6:0];
    assign w_freq_sat = (w_num_nx > 32'd65535) ? 16'hFFFF  : w_num_nx[15:0];

    assign busy = (r_state != S_IDLE);

    // Two-flop synchronizer plus one delay stage for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_pwm_s <= 1'b0;
            r_pwm_d <= 1'b0;
        end else begin
            r_sync1 <= pwm_in;
            r_pwm_s <= r_sync1;
            r_pwm_d <= r_pwm_s;
        end
    end

    // Period and high-time counters, restarted by every rise and saturating at the timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_hcnt <= '0;
        end else if (w_rise) begin
            r_cnt  <= L_ONE;
            r_hcnt <= L_ONE;
        end else begin
            if (r_cnt < L_TIMEOUT) begin
                r_cnt <= r_cnt + L_ONE;
            end
            if (r_pwm_s && (r_hcnt < L_TIMEOUT)) begin
                r_hcnt <= r_hcnt + L_ONE;
            end
        end
    end

    // Capture, two sequential divisions and registered result/timeout reporting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_armed    <= 1'b0;
            r_to_fired <= 1'b0;
            r_p        <= '0;
            r_h        <= '0;
            r_num      <= '0;
            r_rem      <= '0;
            r_den      <= '0;
            r_bit      <= '0;
            r_duty     <= '0;
            period_cyc <= '0;
            high_cyc   <= '0;
            duty_pct   <= '0;
            freq_hz    <= '0;
            meas_valid <= 1'b0;
            no_signal  <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        if (!r_armed) begin
                            r_armed <= 1'b1;
                        end else begin
                            r_p     <= r_cnt;
                            r_h     <= w_h_cap;
                            r_num   <= w_duty_num;
                            r_rem   <= '0;
                            r_den   <= 32'(r_cnt);
                            r_bit   <= '0;
                            r_state <= S_DIV_DUTY;
                        end
                    end else if (w_timeout) begin
                        period_cyc <= '0;
                        high_cyc   <= '0;
                        freq_hz    <= '0;
                        duty_pct   <= r_pwm_s ? 7'd100 : 7'd0;
                        no_signal  <= 1'b1;
                        meas_valid <= 1'b1;
                        r_armed    <= 1'b0;
                        r_to_fired <= 1'b1;
                    end
                end
                S_DIV_DUTY: begin
                    r_num <= w_num_nx;
                    r_rem <= w_rem_nx;
                    r_bit <= r_bit + 5'd1;
                    if (r_bit == 5'd31) begin
                        // Divisor (period) is reused; reload the dividend with the clock rate.
                        r_duty  <= w_duty_sat;
                        r_num   <= L_CLK_HZ;
                        r_rem   <= '0;
                        r_state <= S_DIV_FREQ;
                    end
                end
                S_DIV_FREQ: begin
                    r_num <= w_num_nx;
                    r_rem <= w_rem_nx;
                    r_bit <= r_bit + 5'd1;
                    if (r_bit == 5'd31) begin
                        // Results land on entry to DONE so meas_valid is high during DONE.
                        period_cyc <= r_p;
                        high_cyc   <= r_h;
                        duty_pct   <= r_duty;
                        freq_hz    <= w_freq_sat;
                        no_signal  <= 1'b0;
                        meas_valid <= 1'b1;
                        r_to_fired <= 1'b0;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_meter.sv
// Randomized PWM stimulus with a scoreboard fed by an edge-level reference model.
// Stimulus is driven on negedges; the monitor samples on negedges and pops expectations on meas_valid.
// Timeout, busy-drop, saturation and mid-division reset scenarios are included.
module tb_pwm_meter;

    localparam int CLK_HZ  = 1_000_000;
    localparam int CNT_W   = 24;
    localparam int TIMEOUT = 3000;
    localparam int LAT     = 67;  // drive cycle of rise -> meas_valid cycle (2 sync + 65)
    localparam int GAP     = 66;  // minimum rise spacing for a capture to be accepted
    localparam int TO_LAT  = TIMEOUT + 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             pwm_in = 1'b0;
    logic [CNT_W-1:0] period_cyc;
    logic [CNT_W-1:0] high_cyc;
    logic [6:0]       duty_pct;
    logic [15:0]      freq_hz;
    logic             meas_valid;
    logic             no_signal;
    logic             busy;

    pwm_meter #(
        .CLK_HZ (CLK_HZ),
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pwm_in    (pwm_in),
        .period_cyc(period_cyc),
        .high_cyc  (high_cyc),
        .duty_pct  (duty_pct),
        .freq_hz   (freq_hz),
        .meas_valid(meas_valid),
        .no_signal (no_signal),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int period;
        int high;
        int duty;
        int freq;
        int nosig;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state
    bit m_armed    = 1'b0;
    bit m_to_fired = 1'b0;
    int m_last_cap = -1000;
    int m_prev_k   = 0;
    int m_prev_h   = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int c, input int p, input int h, input int d, input int f, input int ns);
        exp_t e;
        e.cyc = c; e.period = p; e.high = h; e.duty = d; e.freq = f; e.nosig = ns;
        sbq.push_back(e);
    endtask

    // A rise driven at cycle k whose pulse will be h cycles high.
    task automatic model_rise(input int k, input int h);
        int p, d, f;
        if (!m_armed) begin
            m_armed = 1'b1;
        end else if (k - m_last_cap >= GAP) begin
            p = k - m_prev_k;
            d = (m_prev_h * 100) / p;
            if (d > 100) d = 100;
            f = CLK_HZ / p;
            if (f > 65535) f = 65535;
            push(k + LAT, p, m_prev_h, d, f, 0);
            m_last_cap = k;
            m_to_fired = 1'b0;
        end
        m_prev_k = k;
        m_prev_h = h;
    endtask

    task automatic model_reset();
        m_armed    = 1'b0;
        m_to_fired = 1'b0;
        m_last_cap = -1000;
    endtask

    // Called at a negedge; returns at the negedge where the next rise may be driven.
    task automatic pulse(input int p, input int h);
        pwm_in = 1'b1;
        model_rise(cyc, h);
        repeat (h) @(negedge clk);
        pwm_in = 1'b0;
        repeat (p - h) @(negedge clk);
    endtask

    task automatic rand_pulse();
        int p, h;
        if ($urandom_range(1, 0) == 1) p = int'($urandom_range(20, 4));
        else                           p = int'($urandom_range(400, 70));
        h = int'($urandom_range(p - 1, 1));
        pulse(p, h);
    endtask

    // Hold the input stuck at a level long enough to provoke the timeout report.
    task automatic stuck(input bit level);
        int k;
        if (level) begin
            pwm_in = 1'b1;
            k = cyc;
            model_rise(k, 0);
        end else begin
            k = m_prev_k;
        end
        if (!m_to_fired) push(k + TO_LAT, 0, 0, level ? 100 : 0, 0, 1);
        m_armed    = 1'b0;
        m_to_fired = 1'b1;
        repeat (TIMEOUT + 10) @(negedge clk);
        pwm_in = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_period"}, int'(period_cyc), 0);
        check({tag, "_high"}, int'(high_cyc), 0);
        check({tag, "_duty"}, int'(duty_pct), 0);
        check({tag, "_freq"}, int'(freq_hz), 0);
        check({tag, "_meas_valid"}, int'(meas_valid), 0);
        check({tag, "_no_signal"}, int'(no_signal), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    // Monitor: pops one expectation per meas_valid pulse and flags missed pulses.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                e = sbq.pop_front();
                checks++;
                failures++;
                $display("FAIL missing_meas_valid: got none, expected pulse at cycle %0d", e.cyc);
            end
            if (rst_n && meas_valid) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_meas_valid: got pulse at cycle %0d, expected none", cyc);
                end else begin
                    e = sbq.pop_front();
                    check("mv_cycle", cyc, e.cyc);
                    check("period_cyc", int'(period_cyc), e.period);
                    check("high_cyc", int'(high_cyc), e.high);
                    check("duty_pct", int'(duty_pct), e.duty);
                    check("freq_hz", int'(freq_hz), e.freq);
                    check("no_signal", int'(no_signal), e.nosig);
                    if (e.nosig == 0) check("busy_in_done", int'(busy), 1);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        repeat (4) pulse(100, 30);     // 30 % duty, 10 kHz
        repeat (3) pulse(200, 198);    // 99 % duty, 5 kHz
        repeat (15) pulse(10, 5);      // saturated frequency, captures dropped while busy
        repeat (40) rand_pulse();

        stuck(1'b1);                   // stuck high -> duty 100, no_signal
        check("no_signal_level_hi", int'(no_signal), 1);
        repeat (4) rand_pulse();
        repeat (2) pulse(150, 60);
        stuck(1'b0);                   // stuck low -> duty 0
        check("no_signal_level_lo", int'(no_signal), 1);
        repeat (3) pulse(120, 40);
        check("no_signal_cleared", int'(no_signal), 0);

        // Reset in the middle of the frequency division.
        repeat (2) pulse(200, 50);
        pwm_in = 1'b1;
        model_rise(cyc, 50);
        repeat (45) @(negedge clk);
        pwm_in = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_zero_outputs("midreset");
        while (sbq.size() > 0 && sbq[sbq.size()-1].cyc > cyc) void'(sbq.pop_back());
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) pulse(90, 45);
        repeat (6) rand_pulse();

        repeat (200) @(negedge clk);
        check("scoreboard_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
